// File: rtl/delay_line_arbiter.sv
// Round-robin arbiter feeding a shared DEPTH-stage, 1-bit delay line.
// The granted requester's bit travels with its id and leaves DEPTH advancing edges later.
module delay_line_arbiter #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 2,
  parameter int IDW   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] din,
  input  logic            stall,
  output logic [NREQ-1:0] gnt,
  output logic            out_valid,
  output logic [IDW-1:0]  out_id,
  output logic            out,
  output logic            busy
);

  // Handshake: there is no back-pressure on requesters. gnt[i] high in a cycle
  // means req[i] and din[i] are consumed at the closing rising edge; a request
  // that is not granted (or arrives during stall/reset) is simply not taken.
  logic [IDW-1:0]  ptr;
  logic [DEPTH-1:0] st_valid;
  logic [DEPTH-1:0] st_data;
  logic [IDW-1:0]  st_id [DEPTH];

  logic            grant_valid;
  logic            grant_data;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  ptr_next;

  // Two passes give the rotated scan: first ids >= ptr, then the wrap to ids < ptr.
  always_comb begin
    gnt         = '0;
    grant_valid = 1'b0;
    grant_id    = '0;
    grant_data  = 1'b0;
    if (rst_n && !stall) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_valid && req[i] && (IDW'(i) >= ptr)) begin
          grant_valid = 1'b1;
          grant_id    = IDW'(i);
          grant_data  = din[i];
          gnt[i]      = 1'b1;
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_valid && req[i] && (IDW'(i) < ptr)) begin
          grant_valid = 1'b1;
          grant_id    = IDW'(i);
          grant_data  = din[i];
          gnt[i]      = 1'b1;
        end
      end
    end
  end

  assign ptr_next = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr      <= '0;
      st_valid <= '0;
      st_data  <= '0;
      for (int k = 0; k < DEPTH; k++) st_id[k] <= '0;
    end else if (!stall) begin
      st_valid[0] <= grant_valid;
      st_data[0]  <= grant_data;
      st_id[0]    <= grant_id;
      for (int k = 1; k < DEPTH; k++) begin
        st_valid[k] <= st_valid[k-1];
        st_data[k]  <= st_data[k-1];
        st_id[k]    <= st_id[k-1];
      end
      if (grant_valid) ptr <= ptr_next;
    end
  end

  assign out_valid = st_valid[DEPTH-1];
  assign out_id    = st_id[DEPTH-1];
  assign out       = st_data[DEPTH-1];
  assign busy      = |st_valid;

endmodule

// File: tb/tb_delay_line_arbiter.sv
// Bench for delay_line_arbiter: directed scenarios plus a random run, with an
// expected-item queue that is checked as items leave the delay line.
module tb_delay_line_arbiter;
  localparam int NREQ  = 4;
  localparam int DEPTH = 2;
  localparam int IDW   = 2;
  localparam int W     = IDW + 1;

  logic            clk;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] din;
  logic            stall;
  logic [NREQ-1:0] gnt;
  logic            out_valid;
  logic [IDW-1:0]  out_id;
  logic            out;
  logic            busy;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic         adv = 1'b0;

  delay_line_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .stall(stall),
    .gnt(gnt), .out_valid(out_valid), .out_id(out_id), .out(out), .busy(busy)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  // The output stage only advances on edges with rst_n=1 and stall=0.
  always @(posedge clk) adv = (rst_n === 1'b1) && (stall === 1'b0);

  // scoreboard: one pop per item that newly reaches the output stage
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (adv && out_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got id=%0d data=%0b, expected nothing", out_id, out);
      end else begin
        e = exp_q.pop_front();
        if ({out_id, out} !== e) begin
          bad++;
          $display("FAIL sb_item: got id=%0d data=%0b, expected id=%0d data=%0b",
                   out_id, out, e[W-1:1], e[0]);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req = '0;
    din = '0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; din = 4'b1111; stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_id !== 2'd0) begin bad++; $display("FAIL reset_out_id: got %0d want 0", out_id); end
    total++; if (out !== 1'b0) begin bad++; $display("FAIL reset_out: got %b want 0", out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    tick();
    rst_n = 1'b1; din = 4'b0001;
    @(negedge clk);
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL reset_first_grant: got %b want 0001", gnt); end
    exp_q.push_back({2'd0, 1'b1});
    tick();
    idle(DEPTH + 2);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL reset_drain: %0d items left want 0", exp_q.size()); end
  endtask

  // ptr is 1 on entry
  task automatic test_single();
    req = 4'b0100; din = 4'b0100;
    @(negedge clk);
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt: got %b want 0100", gnt); end
    exp_q.push_back({2'd2, 1'b1});
    tick();
    req = '0; din = '0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_t1_valid: got %b want 0", out_valid); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_t1_busy: got %b want 1", busy); end
    tick();
    @(negedge clk);
    total++; if ({out_valid, out_id, out} !== 4'b1_10_1) begin bad++; $display("FAIL single_t2_out: got v=%b id=%0d d=%b want v=1 id=2 d=1", out_valid, out_id, out); end
    tick();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_t3_valid: got %b want 0", out_valid); end
    idle(DEPTH);
  endtask

  task automatic test_rotation();
    logic [NREQ-1:0] pat;
    int id;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    pat = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      req = 4'b1111; din = pat;
      id = k % NREQ;
      @(negedge clk);
      total++; if (gnt !== (4'b0001 << id)) begin bad++; $display("FAIL rotation_gnt%0d: got %b want %b", k, gnt, 4'b0001 << id); end
      exp_q.push_back({IDW'(id), pat[id]});
      tick();
    end
    idle(DEPTH + 2);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rotation_drain: %0d items left want 0", exp_q.size()); end
  endtask

  // ptr is 2 on entry
  task automatic test_wrap();
    logic [NREQ-1:0] reqs [4];
    logic [NREQ-1:0] gnts [4];
    int ids [4];
    reqs = '{4'b0100, 4'b0001, 4'b1001, 4'b1001};
    gnts = '{4'b0100, 4'b0001, 4'b1000, 4'b0001};
    ids  = '{2, 0, 3, 0};
    for (int k = 0; k < 4; k++) begin
      req = reqs[k]; din = NREQ'($urandom_range(0, 15));
      @(negedge clk);
      total++; if (gnt !== gnts[k]) begin bad++; $display("FAIL wrap_gnt%0d: got %b want %b", k, gnt, gnts[k]); end
      exp_q.push_back({IDW'(ids[k]), din[ids[k]]});
      tick();
    end
    idle(DEPTH + 2);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL wrap_drain: %0d items left want 0", exp_q.size()); end
  endtask

  // ptr is 1 on entry
  task automatic test_stall();
    req = 4'b0010; din = 4'b0000;
    @(negedge clk);
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL stall_gnt: got %b want 0010", gnt); end
    exp_q.push_back({2'd1, 1'b0});
    tick();
    stall = 1'b1; req = 4'b1111;
    @(negedge clk);
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL stall_gnt_gated: got %b want 0000", gnt); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall_busy: got %b want 1", busy); end
    tick();
    stall = 1'b0; req = '0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_t2_valid: got %b want 0", out_valid); end
    tick();
    stall = 1'b1;
    @(negedge clk);
    total++; if ({out_valid, out_id} !== 3'b1_01) begin bad++; $display("FAIL stall_t3_out: got v=%b id=%0d want v=1 id=1", out_valid, out_id); end
    tick();
    @(negedge clk);
    total++; if ({out_valid, out_id} !== 3'b1_01) begin bad++; $display("FAIL stall_hold_out: got v=%b id=%0d want v=1 id=1", out_valid, out_id); end
    tick();
    stall = 1'b0;
    idle(DEPTH + 1);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stall_drain: %0d items left want 0", exp_q.size()); end
  endtask

  // ptr is 2 on entry; the granted item is discarded by reset, so it is not queued
  task automatic test_midreset();
    req = 4'b1111; din = 4'b1111;
    @(negedge clk);
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL midreset_gnt: got %b want 0100", gnt); end
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL midreset_gnt_gated: got %b want 0000", gnt); end
    tick();
    rst_n = 1'b1; req = 4'b1010; din = 4'b0010;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b want 0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid: got %b want 0", out_valid); end
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL midreset_rescan: got %b want 0010", gnt); end
    exp_q.push_back({2'd1, 1'b1});
    tick();
    req = '0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_no_pulse: got %b want 0", out_valid); end
    idle(DEPTH + 1);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL midreset_drain: %0d items left want 0", exp_q.size()); end
  endtask

  // ptr is 2 on entry; reference round-robin model tracks the pointer
  task automatic test_random();
    int mp;
    int want;
    int cand;
    logic [NREQ-1:0] exp_gnt;
    mp = 2;
    for (int k = 0; k < 300; k++) begin
      req   = NREQ'($urandom_range(0, 15));
      din   = NREQ'($urandom_range(0, 15));
      stall = ($urandom_range(0, 3) == 0);
      want  = -1;
      if (!stall) begin
        for (int j = 0; j < NREQ; j++) begin
          cand = (mp + j) % NREQ;
          if (want < 0 && req[cand]) want = cand;
        end
      end
      exp_gnt = (want < 0) ? '0 : (4'b0001 << want);
      @(negedge clk);
      total++; if (gnt !== exp_gnt) begin bad++; $display("FAIL random_gnt%0d: got %b want %b", k, gnt, exp_gnt); end
      if (want >= 0) begin
        exp_q.push_back({IDW'(want), din[want]});
        mp = (want + 1) % NREQ;
      end
      tick();
    end
    stall = 1'b0;
    idle(DEPTH + 2);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL random_drain: %0d items left want 0", exp_q.size()); end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; din = '0; stall = 1'b0;
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_stall();
    test_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
